// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle data-memory access unit between the CPU
// datapath and a variable-latency data memory. Handles byte/half/word
// loads and stores, lane steering, sign/zero extension, alignment and
// funct3 checking, and a bounded wait for memory completion.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [2:0]  i_cpu_funct3,
    output logic        o_cpu_stall,
    output logic        o_cpu_done,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_err,
    output logic        o_mem_valid,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic            r_we;
    logic [31:0]     r_addr;
    logic [2:0]      r_funct3;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic [CW-1:0]   r_tmo_cnt;

    logic            w_req_bad;
    logic            w_tmo_hit;

    // Loads accept LB/LH/LW/LBU/LHU; stores accept SB/SH/SW only.
    function automatic logic f_is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Size is funct3[1:0]; halves need an even address, words a multiple of four.
    function automatic logic f_is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte enables for a store of the given size at byte offset a.
    function automatic logic [3:0] f_store_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] strb;
        strb = 4'b0000;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << a;
            2'b01:   strb = 4'b0011 << a;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replicate the store data so every lane carries it; wstrb picks the lane.
    function automatic logic [31:0] f_store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] res;
        res = 32'h0000_0000;
        case (f3[1:0])
            2'b00:   res = {4{d[7:0]}};
            2'b01:   res = {2{d[15:0]}};
            2'b10:   res = d;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Select the addressed byte/half from the read word and extend it.
    function automatic logic [31:0] f_load_format(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = 8'h00;
        h   = 16'h0000;
        res = 32'h0000_0000;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        if (a[1]) begin
            h = w[31:16];
        end else begin
            h = w[15:0];
        end
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = w;
            3'b100:  res = {24'h00_0000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign w_req_bad = !f_is_legal(i_cpu_we, i_cpu_funct3) ||
                       f_is_misaligned(i_cpu_funct3, i_cpu_addr[1:0]);
    assign w_tmo_hit = (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: bad requests skip memory, ACCESS ends on ready or timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_cpu_req) begin
                    if (w_req_bad) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_ACCESS;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (i_mem_ready || w_tmo_hit) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, load-data capture, error flag and saturating timeout counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_we      <= 1'b0;
            r_addr    <= 32'h0000_0000;
            r_funct3  <= 3'b000;
            r_wdata   <= 32'h0000_0000;
            r_wstrb   <= 4'b0000;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0000_0000;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cpu_req) begin
                        r_we      <= i_cpu_we;
                        r_addr    <= i_cpu_addr;
                        r_funct3  <= i_cpu_funct3;
                        r_wdata   <= i_cpu_we ? f_store_data(i_cpu_funct3, i_cpu_wdata) : 32'h0000_0000;
                        r_wstrb   <= i_cpu_we ? f_store_strb(i_cpu_funct3, i_cpu_addr[1:0]) : 4'b0000;
                        r_err     <= w_req_bad;
                        r_rdata   <= 32'h0000_0000;
                        r_tmo_cnt <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (i_mem_ready) begin
                        r_rdata <= r_we ? 32'h0000_0000 : f_load_format(r_funct3, r_addr[1:0], i_mem_rdata);
                        r_err   <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                    end
                    if (r_tmo_cnt != CW'(TIMEOUT_CYCLES)) begin
                        r_tmo_cnt <= r_tmo_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    r_tmo_cnt <= r_tmo_cnt;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded from state and latched request; memory fields are zero outside ACCESS.
    always_comb begin
        o_cpu_stall = 1'b0;
        o_cpu_done  = 1'b0;
        o_cpu_err   = 1'b0;
        o_cpu_rdata = 32'h0000_0000;
        o_mem_valid = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 32'h0000_0000;
        o_mem_wdata = 32'h0000_0000;
        o_mem_wstrb = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                o_cpu_stall = i_cpu_req;
            end
            ST_ACCESS: begin
                o_cpu_stall = 1'b1;
                o_mem_valid = 1'b1;
                o_mem_we    = r_we;
                o_mem_addr  = {r_addr[31:2], 2'b00};
                o_mem_wdata = r_wdata;
                o_mem_wstrb = r_wstrb;
            end
            ST_RESP: begin
                o_cpu_done = 1'b1;
                o_cpu_err  = r_err;
                if (r_err) begin
                    o_cpu_rdata = 32'h0000_0000;
                end else begin
                    o_cpu_rdata = r_rdata;
                end
            end
            default: begin
                o_cpu_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small word-addressed memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic        cpu_stall;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_abs = 0;

    logic [31:0] mem_model [0:63];

    // Observations from the most recent run_access call.
    int          obs_done_cyc;
    int          obs_done_abs;
    int          obs_first_valid_abs;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_stall0;
    logic        obs_stall1;
    logic        obs_stall_done;
    logic        obs_valid_seen;
    logic        obs_stable;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;

    mem_access_unit #(.TIMEOUT_CYCLES(64)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_funct3 (cpu_funct3),
        .o_cpu_stall  (cpu_stall),
        .o_cpu_done   (cpu_done),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_err    (cpu_err),
        .o_mem_valid  (mem_valid),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wstrb  (mem_wstrb),
        .i_mem_ready  (mem_ready),
        .i_mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    // Issue one request at cycle 0 and play memory: ready at cycle 1+delay (never if delay < 0).
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input int delay);
        int cyc;
        logic [5:0] idx;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_funct3 = f3;
        obs_done_cyc = -1; obs_done_abs = -1; obs_first_valid_abs = -1;
        obs_valid_seen = 1'b0; obs_stable = 1'b1; obs_stall0 = 1'b0; obs_stall1 = 1'b0;
        obs_stall_done = 1'b1; obs_rdata = 32'hXXXX_XXXX; obs_err = 1'bx;
        obs_we = 1'b0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_wstrb = 4'h0;
        cyc = 0;
        while (obs_done_cyc < 0 && cyc < 100) begin
            mem_ready = (delay >= 0) && (cyc == delay + 1);
            idx = addr[7:2];
            mem_rdata = mem_ready ? mem_model[idx] : 32'h5A5A_5A5A;
            @(negedge clk);
            if (cyc == 0) obs_stall0 = cpu_stall;
            if (cyc == 1) obs_stall1 = cpu_stall;
            if (mem_valid) begin
                if (!obs_valid_seen) begin
                    obs_valid_seen = 1'b1;
                    obs_first_valid_abs = cyc_abs;
                    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
                end else if (mem_we !== obs_we || mem_addr !== obs_addr ||
                             mem_wdata !== obs_wdata || mem_wstrb !== obs_wstrb) begin
                    obs_stable = 1'b0;
                end
                if (mem_ready && mem_we) begin
                    idx = mem_addr[7:2];
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wstrb[b]) mem_model[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
            end
            if (cpu_done) begin
                obs_done_cyc = cyc; obs_done_abs = cyc_abs;
                obs_rdata = cpu_rdata; obs_err = cpu_err; obs_stall_done = cpu_stall;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        cpu_req = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({cpu_stall, cpu_done, cpu_err, mem_valid, mem_we} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {cpu_stall, cpu_done, cpu_err, mem_valid, mem_we});
        end
        n_cmp++;
        if ({cpu_rdata, mem_addr, mem_wdata, mem_wstrb} !== 100'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {cpu_rdata, mem_addr, mem_wdata, mem_wstrb});
        end
    endtask

    task automatic test_store_word();
        run_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 0);
        n_cmp++;
        if (obs_done_cyc !== 2 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_done: got cyc=%0d err=%b rdata=%h expected cyc=2 err=0 rdata=0",
                     obs_done_cyc, obs_err, obs_rdata);
        end
        n_cmp++;
        if (obs_wstrb !== 4'b1111 || obs_addr !== 32'h10 || obs_wdata !== 32'hDEAD_BEEF || obs_we !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_fields: got we=%b addr=%h wdata=%h wstrb=%b expected 1 00000010 deadbeef 1111",
                     obs_we, obs_addr, obs_wdata, obs_wstrb);
        end
    endtask

    task automatic test_lw_immediate();
        run_access(1'b0, 32'h0000_0010, 32'h0, 3'b010, 0);
        n_cmp++;
        if (obs_stall0 !== 1'b1 || obs_stall1 !== 1'b1 || obs_stall_done !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_stall: got c0=%b c1=%b c2=%b expected 1 1 0", obs_stall0, obs_stall1, obs_stall_done);
        end
        n_cmp++;
        if (obs_done_cyc !== 2 || obs_rdata !== 32'hDEAD_BEEF || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_data: got cyc=%0d rdata=%h err=%b expected cyc=2 deadbeef err=0",
                     obs_done_cyc, obs_rdata, obs_err);
        end
        n_cmp++;
        if (obs_wstrb !== 4'b0000 || obs_we !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_strb: got we=%b wstrb=%b expected 0 0000", obs_we, obs_wstrb);
        end
    endtask

    task automatic test_byte_half_loads();
        logic [31:0] addrs [4];
        logic [2:0]  f3s   [4];
        logic [31:0] exps  [4];
        addrs[0] = 32'h13; f3s[0] = 3'b000; exps[0] = 32'hFFFF_FFDE;
        addrs[1] = 32'h13; f3s[1] = 3'b100; exps[1] = 32'h0000_00DE;
        addrs[2] = 32'h12; f3s[2] = 3'b001; exps[2] = 32'hFFFF_DEAD;
        addrs[3] = 32'h10; f3s[3] = 3'b101; exps[3] = 32'h0000_BEEF;
        for (int i = 0; i < 4; i++) begin
            run_access(1'b0, addrs[i], 32'h0, f3s[i], 0);
            n_cmp++;
            if (obs_rdata !== exps[i] || obs_err !== 1'b0 || obs_done_cyc !== 2) begin
                n_fail++;
                $display("FAIL load_%0d: got rdata=%h err=%b cyc=%0d expected %h err=0 cyc=2",
                         i, obs_rdata, obs_err, obs_done_cyc, exps[i]);
            end
        end
    endtask

    task automatic test_stores();
        run_access(1'b1, 32'h0000_0012, 32'h0000_00AB, 3'b000, 0);
        n_cmp++;
        if (obs_wstrb !== 4'b0100 || obs_wdata !== 32'hABAB_ABAB || obs_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL sb_fields: got wstrb=%b wdata=%h addr=%h expected 0100 abababab 00000010",
                     obs_wstrb, obs_wdata, obs_addr);
        end
        run_access(1'b1, 32'h0000_0012, 32'h0000_1234, 3'b001, 0);
        n_cmp++;
        if (obs_wstrb !== 4'b1100 || obs_wdata !== 32'h1234_1234 || obs_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL sh_fields: got wstrb=%b wdata=%h addr=%h expected 1100 12341234 00000010",
                     obs_wstrb, obs_wdata, obs_addr);
        end
        // SB wrote 0xAB to byte 2, then SH overwrote bytes 2..3 with 0x1234.
        run_access(1'b0, 32'h0000_0010, 32'h0, 3'b010, 0);
        n_cmp++;
        if (obs_rdata !== 32'h1234_BEEF) begin
            n_fail++;
            $display("FAIL store_readback: got %h expected 1234beef", obs_rdata);
        end
    endtask

    task automatic test_misaligned_illegal();
        logic        wes   [4];
        logic [31:0] addrs [4];
        logic [2:0]  f3s   [4];
        wes[0] = 1'b0; addrs[0] = 32'h11; f3s[0] = 3'b010;
        wes[1] = 1'b0; addrs[1] = 32'h10; f3s[1] = 3'b011;
        wes[2] = 1'b1; addrs[2] = 32'h13; f3s[2] = 3'b001;
        wes[3] = 1'b1; addrs[3] = 32'h10; f3s[3] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            run_access(wes[i], addrs[i], 32'hFFFF_FFFF, f3s[i], 0);
            n_cmp++;
            if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_valid_seen !== 1'b0 || obs_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL bad_req_%0d: got cyc=%0d err=%b valid=%b rdata=%h expected cyc=1 err=1 valid=0 rdata=0",
                         i, obs_done_cyc, obs_err, obs_valid_seen, obs_rdata);
            end
        end
    endtask

    task automatic test_wait_states();
        run_access(1'b0, 32'h0000_0010, 32'h0, 3'b010, 5);
        n_cmp++;
        if (obs_done_cyc !== 7 || obs_stable !== 1'b1 || obs_rdata !== 32'h1234_BEEF) begin
            n_fail++;
            $display("FAIL wait5: got cyc=%0d stable=%b rdata=%h expected cyc=7 stable=1 1234beef",
                     obs_done_cyc, obs_stable, obs_rdata);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 32'h0000_0010, 32'h0, 3'b010, -1);
        n_cmp++;
        if (obs_done_cyc !== 65 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_valid_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout: got cyc=%0d err=%b rdata=%h valid=%b expected cyc=65 err=1 rdata=0 valid=1",
                     obs_done_cyc, obs_err, obs_rdata, obs_valid_seen);
        end
    endtask

    task automatic test_reset_mid_access();
        logic saw_done;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0; cpu_funct3 = 3'b010;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got mem_valid=%b expected 1", mem_valid);
        end
        #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_stall, cpu_done, cpu_err, mem_valid, mem_we, cpu_rdata, mem_addr, mem_wdata, mem_wstrb} !== 105'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b stall=%b done=%b addr=%h expected all 0",
                     mem_valid, cpu_stall, cpu_done, mem_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (cpu_done || mem_valid) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_abandon: got activity=%b expected 0", saw_done);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        run_access(1'b0, 32'h0000_0010, 32'h0, 3'b010, 0);
        first_done = obs_done_abs;
        n_cmp++;
        if (obs_done_cyc !== 2 || obs_rdata !== 32'h1234_BEEF) begin
            n_fail++;
            $display("FAIL b2b_first: got cyc=%0d rdata=%h expected cyc=2 1234beef", obs_done_cyc, obs_rdata);
        end
        run_access(1'b0, 32'h0000_0010, 32'h0, 3'b010, 0);
        // RESP, then the accepting IDLE cycle, then mem_valid.
        n_cmp++;
        if (obs_first_valid_abs - first_done !== 2) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles expected 2", obs_first_valid_abs - first_done);
        end
        n_cmp++;
        if (obs_done_cyc !== 2 || obs_rdata !== 32'h1234_BEEF || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got cyc=%0d rdata=%h err=%b expected cyc=2 1234beef 0",
                     obs_done_cyc, obs_rdata, obs_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_funct3 = 3'b000;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        test_store_word();
        test_lw_immediate();
        test_byte_half_loads();
        test_stores();
        test_misaligned_illegal();
        test_wait_states();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
